// File: rtl/fht_pkg.sv
// Shared definitions for the FHT host-side I/O path: frame geometry, control
// states and the bit-reversal used to scatter input samples across the banks.
package fht_pkg;

    localparam int N_POINT = 1024;
    localparam int N_BANK  = 4;
    localparam int LOG2_N  = 10;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        WAIT_BUSY,
        WAIT_DONE,
        UNLOAD,
        DRAIN
    } state_e;

    function automatic logic [LOG2_N-1:0] bitrev10(input logic [LOG2_N-1:0] n);
        logic [LOG2_N-1:0] r;
        for (int i = 0; i < LOG2_N; i++) begin
            r[i] = n[LOG2_N-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/fht_out_skid.sv
// Small synchronous FIFO absorbing RAM read data in flight while the output
// stream is stalled; entries carry the sample plus its end-of-frame flag.
module fht_out_skid #(
    parameter int DEPTH = 3,
    parameter int W     = 17,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  logic [W-1:0]  push_data_i,
    output logic          out_valid_o,
    output logic [W-1:0]  out_data_o,
    input  logic          out_ready_i,
    output logic [CW-1:0] count_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] cnt_q;
    logic          pop, do_push;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign out_valid_o = (cnt_q != '0);
    assign out_data_o  = mem_q[rd_ptr_q];
    assign count_o     = cnt_q;
    assign pop         = out_valid_o & out_ready_i;
    // A push into a full FIFO is legal only when the head leaves in the same cycle.
    assign do_push     = push_i & ((cnt_q != CW'(DEPTH)) | pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({do_push, pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/fht_io_control.sv
// Loads a 1024-sample frame into bank set A in bit-reversed order, kicks the
// FHT controller, then streams the result back out in natural order.
module fht_io_control
    import fht_pkg::*;
#(
    parameter int A_BIT  = 8,
    parameter int D_BIT  = 16,
    parameter int RD_LAT = 2
) (
    input  logic               iCLK,
    input  logic               iRESET,
    input  logic               iIN_VALID,
    input  logic [D_BIT-1:0]   iIN_DATA,
    output logic               oIN_READY,
    output logic [D_BIT-1:0]   oWR_DATA,
    output logic [3:0]         oWE,
    output logic [A_BIT-1:0]   oADDR_WR,
    output logic               oFHT_START,
    input  logic               iFHT_RDY,
    input  logic               iSRC_SEL,
    output logic [A_BIT-1:0]   oADDR_RD,
    output logic               oRD_SET,
    input  logic [4*D_BIT-1:0] iRD_DATA,
    output logic               oOUT_VALID,
    output logic [D_BIT-1:0]   oOUT_DATA,
    input  logic               iOUT_READY,
    output logic               oOUT_LAST,
    output logic               oBUSY
);

    localparam int DEPTH = RD_LAT + 1;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam logic [LOG2_N-1:0] LAST_IDX = LOG2_N'(N_POINT - 1);

    state_e              state_q, state_d;
    logic [LOG2_N-1:0]   in_cnt_q, rd_cnt_q;
    logic                rd_set_q;
    logic [N_BANK-1:0]   we_q;
    logic [A_BIT-1:0]    addr_wr_q;
    logic [D_BIT-1:0]    wr_data_q;
    logic [RD_LAT-1:0]   tag_vld_q;
    logic [1:0]          tag_bank_q [RD_LAT];
    logic                tag_last_q [RD_LAT];

    logic                in_ready, accept, issue, pop, push;
    logic [LOG2_N-1:0]   rev;
    logic [CW-1:0]       fifo_cnt, inflight;
    logic [D_BIT-1:0]    rd_word;
    logic                fifo_valid;
    logic [D_BIT:0]      fifo_head;

    assign in_ready = (state_q == IDLE) || (state_q == LOAD);
    assign accept   = iIN_VALID & in_ready;
    assign rev      = bitrev10(in_cnt_q);
    assign pop      = fifo_valid & iOUT_READY;
    assign push     = tag_vld_q[RD_LAT-1];

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight = inflight + CW'(tag_vld_q[i]);
        end
    end

    // Credit check: a slot freed by this cycle's pop may be claimed by a new read.
    assign issue = (state_q == UNLOAD) &&
                   ((32'(fifo_cnt) + 32'(inflight) + 32'd1) <= (32'(DEPTH) + 32'(pop)));

    always_comb begin
        rd_word = iRD_DATA[D_BIT-1:0];
        case (tag_bank_q[RD_LAT-1])
            2'd0:    rd_word = iRD_DATA[D_BIT-1:0];
            2'd1:    rd_word = iRD_DATA[2*D_BIT-1:D_BIT];
            2'd2:    rd_word = iRD_DATA[3*D_BIT-1:2*D_BIT];
            default: rd_word = iRD_DATA[4*D_BIT-1:3*D_BIT];
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (accept) state_d = LOAD;
            LOAD:      if (accept && (in_cnt_q == LAST_IDX)) state_d = START;
            START:     state_d = WAIT_BUSY;
            WAIT_BUSY: if (!iFHT_RDY) state_d = WAIT_DONE;
            WAIT_DONE: if (iFHT_RDY) state_d = UNLOAD;
            UNLOAD:    if (issue && (rd_cnt_q == LAST_IDX)) state_d = DRAIN;
            DRAIN:     if (pop && fifo_head[D_BIT]) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            state_q   <= IDLE;
            in_cnt_q  <= '0;
            rd_cnt_q  <= '0;
            rd_set_q  <= 1'b0;
            we_q      <= '0;
            addr_wr_q <= '0;
            wr_data_q <= '0;
            tag_vld_q <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                tag_bank_q[i] <= '0;
                tag_last_q[i] <= 1'b0;
            end
        end else begin
            state_q <= state_d;

            if (accept) begin
                we_q      <= N_BANK'(1) << rev[1:0];
                addr_wr_q <= A_BIT'(rev[LOG2_N-1:2]);
                wr_data_q <= iIN_DATA;
                in_cnt_q  <= in_cnt_q + LOG2_N'(1);
            end else begin
                we_q <= '0;
            end

            if ((state_q == WAIT_DONE) && iFHT_RDY) begin
                rd_set_q <= iSRC_SEL;
            end

            if (issue) begin
                rd_cnt_q <= rd_cnt_q + LOG2_N'(1);
            end

            // Bank tag and end-of-frame flag ride alongside each read for RD_LAT cycles.
            tag_vld_q[0]  <= issue;
            tag_bank_q[0] <= rd_cnt_q[1:0];
            tag_last_q[0] <= (rd_cnt_q == LAST_IDX);
            for (int i = 1; i < RD_LAT; i++) begin
                tag_vld_q[i]  <= tag_vld_q[i-1];
                tag_bank_q[i] <= tag_bank_q[i-1];
                tag_last_q[i] <= tag_last_q[i-1];
            end
        end
    end

    fht_out_skid #(
        .DEPTH (DEPTH),
        .W     (D_BIT + 1),
        .CW    (CW)
    ) u_skid (
        .clk_i       (iCLK),
        .rst_ni      (iRESET),
        .push_i      (push),
        .push_data_i ({tag_last_q[RD_LAT-1], rd_word}),
        .out_valid_o (fifo_valid),
        .out_data_o  (fifo_head),
        .out_ready_i (iOUT_READY),
        .count_o     (fifo_cnt)
    );

    assign oIN_READY  = in_ready;
    assign oWE        = we_q;
    assign oADDR_WR   = addr_wr_q;
    assign oWR_DATA   = wr_data_q;
    assign oFHT_START = (state_q == START);
    assign oBUSY      = (state_q != IDLE);
    assign oADDR_RD   = A_BIT'(rd_cnt_q[LOG2_N-1:2]);
    assign oRD_SET    = rd_set_q;
    assign oOUT_VALID = fifo_valid;
    assign oOUT_DATA  = fifo_head[D_BIT-1:0];
    assign oOUT_LAST  = fifo_valid & fifo_head[D_BIT];

endmodule

// File: tb/tb_fht_io_control.sv
// Directed bench for fht_io_control with a mock FHT controller and a bank RAM
// model whose words encode {set, bank address, bank index}.
module tb_fht_io_control;

    localparam int A_BIT  = 8;
    localparam int D_BIT  = 16;
    localparam int RD_LAT = 2;

    logic               iCLK = 1'b0;
    logic               iRESET = 1'b1;
    logic               iIN_VALID = 1'b0;
    logic [D_BIT-1:0]   iIN_DATA = '0;
    logic               oIN_READY;
    logic [D_BIT-1:0]   oWR_DATA;
    logic [3:0]         oWE;
    logic [A_BIT-1:0]   oADDR_WR;
    logic               oFHT_START;
    logic               iFHT_RDY = 1'b1;
    logic               iSRC_SEL = 1'b0;
    logic [A_BIT-1:0]   oADDR_RD;
    logic               oRD_SET;
    logic [4*D_BIT-1:0] iRD_DATA;
    logic               oOUT_VALID;
    logic [D_BIT-1:0]   oOUT_DATA;
    logic               iOUT_READY = 1'b1;
    logic               oOUT_LAST;
    logic               oBUSY;

    int n_tests = 0;
    int n_fail  = 0;

    logic [3:0]       obs_we   [1024];
    logic [A_BIT-1:0] obs_addr [1024];
    logic [7:0]       rd_pipe  [RD_LAT];
    logic [57:0]      out_vec;

    fht_io_control #(
        .A_BIT  (A_BIT),
        .D_BIT  (D_BIT),
        .RD_LAT (RD_LAT)
    ) dut (
        .iCLK       (iCLK),
        .iRESET     (iRESET),
        .iIN_VALID  (iIN_VALID),
        .iIN_DATA   (iIN_DATA),
        .oIN_READY  (oIN_READY),
        .oWR_DATA   (oWR_DATA),
        .oWE        (oWE),
        .oADDR_WR   (oADDR_WR),
        .oFHT_START (oFHT_START),
        .iFHT_RDY   (iFHT_RDY),
        .iSRC_SEL   (iSRC_SEL),
        .oADDR_RD   (oADDR_RD),
        .oRD_SET    (oRD_SET),
        .iRD_DATA   (iRD_DATA),
        .oOUT_VALID (oOUT_VALID),
        .oOUT_DATA  (oOUT_DATA),
        .iOUT_READY (iOUT_READY),
        .oOUT_LAST  (oOUT_LAST),
        .oBUSY      (oBUSY)
    );

    always #5 iCLK = ~iCLK;

    assign out_vec = {oIN_READY, oWE, oADDR_WR, oWR_DATA, oFHT_START, oADDR_RD,
                      oRD_SET, oOUT_VALID, oOUT_DATA, oOUT_LAST, oBUSY};

    // Bank RAM model: registered address path, RD_LAT cycles to data.
    always_ff @(posedge iCLK) begin
        rd_pipe[0] <= oADDR_RD;
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end

    always_comb begin
        iRD_DATA = '0;
        for (int b = 0; b < 4; b++)
            iRD_DATA[b*D_BIT +: D_BIT] = {oRD_SET, 5'd0, rd_pipe[RD_LAT-1], 2'(b)};
    end

    function automatic logic [9:0] ref_rev(input logic [9:0] v);
        logic [9:0] r;
        for (int i = 0; i < 10; i++) r[i] = v[9-i];
        return r;
    endfunction

    task automatic test_reset(input string name);
        @(negedge iCLK);
        iRESET    = 1'b0;
        iIN_VALID = 1'b0;
        #1;
        n_tests++;
        if (out_vec !== {1'b1, 57'd0}) begin
            n_fail++;
            $display("FAIL %s: outputs=%h required=%h", name, out_vec, {1'b1, 57'd0});
        end
        repeat (2) @(negedge iCLK);
        iRESET = 1'b1;
        #1;
        n_tests++;
        if ({oIN_READY, oBUSY, oWE, oOUT_VALID} !== {1'b1, 1'b0, 4'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL %s_release: rdy/busy/we/vld=%b required=1000000", name,
                     {oIN_READY, oBUSY, oWE, oOUT_VALID});
        end
    endtask

    task automatic test_load(input int limit, input int duty_pct, input string name);
        int         n = 0;
        int         cyc = 0;
        int         pn = 0;
        bit         pend = 0;
        logic [9:0] r;
        logic [3:0] ewe = '0;
        logic [7:0] ea = '0;
        logic [15:0] ed = '0;
        while ((n < limit || pend) && cyc < 20000) begin
            @(negedge iCLK);
            cyc++;
            n_tests++;
            if (pend) begin
                obs_we[pn]   = oWE;
                obs_addr[pn] = oADDR_WR;
                if ({oWE, oADDR_WR, oWR_DATA} !== {ewe, ea, ed}) begin
                    n_fail++;
                    $display("FAIL %s_write n=%0d: we/addr/data=%h/%h/%h required=%h/%h/%h",
                             name, pn, oWE, oADDR_WR, oWR_DATA, ewe, ea, ed);
                end
            end else if (oWE !== 4'd0) begin
                n_fail++;
                $display("FAIL %s_idle_we: oWE=%b required=0000", name, oWE);
            end
            pend = 0;
            if (n < limit && $urandom_range(99) < duty_pct) begin
                n_tests++;
                if (oIN_READY !== 1'b1) begin
                    n_fail++;
                    $display("FAIL %s_in_ready n=%0d: oIN_READY=%b required=1", name, n, oIN_READY);
                end
                r         = ref_rev(10'(n));
                ewe       = 4'b0001 << r[1:0];
                ea        = r[9:2];
                ed        = 16'(n * 37) ^ 16'h5A00;
                iIN_VALID = 1'b1;
                iIN_DATA  = ed;
                pn        = n;
                pend      = 1;
                n++;
            end else begin
                iIN_VALID = 1'b0;
                iIN_DATA  = 16'hDEAD;
            end
        end
        iIN_VALID = 1'b0;
        if (n < limit || pend) begin
            n_fail++;
            $display("FAIL %s_timeout: loaded=%0d required=%0d", name, n, limit);
        end
    endtask

    task automatic test_bitrev_points(input string name);
        int         pts [4] = '{1, 3, 512, 1023};
        logic [3:0] wes [4] = '{4'b0001, 4'b0001, 4'b0010, 4'b1000};
        logic [7:0] ads [4] = '{8'd128, 8'd192, 8'd0, 8'd255};
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if ({obs_we[pts[i]], obs_addr[pts[i]]} !== {wes[i], ads[i]}) begin
                n_fail++;
                $display("FAIL %s n=%0d: we/addr=%b/%0d required=%b/%0d", name, pts[i],
                         obs_we[pts[i]], obs_addr[pts[i]], wes[i], ads[i]);
            end
        end
    endtask

    // Entered at the falling edge of the START cycle; leaves in UNLOAD cycle 0.
    task automatic test_start_handshake(input logic sel, input string name);
        int pulses = 0;
        int early = 0;
        int blocked = 0;
        n_tests++;
        if ({oFHT_START, oIN_READY} !== 2'b10) begin
            n_fail++;
            $display("FAIL %s_pulse: start/in_ready=%b required=10", name, {oFHT_START, oIN_READY});
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge iCLK);
            pulses += int'(oFHT_START);
            early  += int'(oOUT_VALID);
        end
        iFHT_RDY  = 1'b0;
        iSRC_SEL  = ~sel;
        iIN_VALID = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge iCLK);
            pulses  += int'(oFHT_START);
            early   += int'(oOUT_VALID);
            blocked += int'(oIN_READY) + int'(!oBUSY) + int'(oWE != 4'd0);
        end
        iIN_VALID = 1'b0;
        n_tests++;
        if ({pulses, early, blocked} !== {32'd0, 32'd0, 32'd0}) begin
            n_fail++;
            $display("FAIL %s_wait: extra_pulses=%0d early_valid=%0d load_leaks=%0d required=0/0/0",
                     name, pulses, early, blocked);
        end
        iFHT_RDY = 1'b1;
        iSRC_SEL = sel;
        @(negedge iCLK);
        iSRC_SEL = ~sel;
        n_tests++;
        if ({oRD_SET, oADDR_RD} !== {sel, 8'd0}) begin
            n_fail++;
            $display("FAIL %s_unload_entry: rd_set/addr_rd=%b/%0d required=%b/0",
                     name, oRD_SET, oADDR_RD, sel);
        end
    endtask

    task automatic test_unload(input bit bp, input logic set_bit, input string name);
        int          k = 0;
        int          cyc = 0;
        int          first = -1;
        int          last_cyc = -1;
        int          stall_left = 0;
        int          r;
        bit          stalled = 0;
        bit          rdy;
        logic [15:0] hold_d = '0;
        logic        hold_l = 1'b0;
        logic [15:0] exp_d;
        while (k < 1024 && cyc < 6000) begin
            if (stalled) begin
                n_tests++;
                if ({oOUT_VALID, oOUT_LAST, oOUT_DATA} !== {1'b1, hold_l, hold_d}) begin
                    n_fail++;
                    $display("FAIL %s_stall_hold: vld/last/data=%b/%b/%h required=1/%b/%h",
                             name, oOUT_VALID, oOUT_LAST, oOUT_DATA, hold_l, hold_d);
                end
            end
            if (oOUT_VALID && first < 0) first = cyc;
            if (!bp) begin
                rdy = 1'b1;
            end else if (stall_left > 0) begin
                rdy = 1'b0;
                stall_left--;
            end else begin
                r = int'($urandom_range(99));
                if (r < 3) begin
                    rdy = 1'b0;
                    stall_left = 9;
                end else begin
                    rdy = (r >= 30);
                end
            end
            iOUT_READY = rdy;
            stalled = oOUT_VALID && !rdy;
            hold_d  = oOUT_DATA;
            hold_l  = oOUT_LAST;
            if (oOUT_VALID && rdy) begin
                exp_d = {set_bit, 5'd0, 10'(k)};
                n_tests++;
                if ({oOUT_LAST, oOUT_DATA} !== {(k == 1023), exp_d}) begin
                    n_fail++;
                    $display("FAIL %s_sample k=%0d: last/data=%b/%h required=%b/%h",
                             name, k, oOUT_LAST, oOUT_DATA, (k == 1023), exp_d);
                end
                k++;
                last_cyc = cyc;
            end
            @(negedge iCLK);
            cyc++;
        end
        iOUT_READY = 1'b1;
        n_tests++;
        if (k != 1024) begin
            n_fail++;
            $display("FAIL %s_timeout: received=%0d required=1024", name, k);
        end
        if (!bp) begin
            n_tests++;
            if (first != RD_LAT + 1 || last_cyc != RD_LAT + 1 + 1023) begin
                n_fail++;
                $display("FAIL %s_latency: first/last cycle=%0d/%0d required=%0d/%0d",
                         name, first, last_cyc, RD_LAT + 1, RD_LAT + 1 + 1023);
            end
        end
        n_tests++;
        if ({oBUSY, oOUT_VALID, oIN_READY} !== 3'b001) begin
            n_fail++;
            $display("FAIL %s_return_idle: busy/vld/in_ready=%b required=001",
                     name, {oBUSY, oOUT_VALID, oIN_READY});
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset("reset_initial");

        test_load(1024, 100, "load_full");
        test_bitrev_points("bitrev_points");
        test_start_handshake(1'b1, "start_a");
        test_unload(1'b0, 1'b1, "unload_stream");

        test_load(1024, 50, "load_gaps");
        test_start_handshake(1'b0, "start_b");
        test_unload(1'b1, 1'b0, "unload_backpressure");

        test_load(500, 100, "load_partial");
        test_reset("reset_midload");
        test_load(1024, 100, "reload");
        test_bitrev_points("bitrev_reload");
        test_start_handshake(1'b1, "start_c");
        test_unload(1'b0, 1'b1, "unload_reload");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fht_io_control.md
Name: fht_io_control

Overview:
- Host-side loader/unloader at the far end of the FHT bank RAMs from the FHT stage controller.
- Accepts N = 1024 input samples as a valid/ready stream. Writes each sample into the 4 x 256-word bank set A in bit-reversed order.
- Pulses start to the FHT controller, waits for its ready, then streams the result out of the bank set holding the final data, in natural order, with backpressure.

Parameters:
- A_BIT, 8, bank address width (256 words per bank)
- D_BIT, 16, sample width
- RD_LAT, 2, bank RAM read latency in cycles (1..3)

Ports:
- iCLK  in  1  clock
- iRESET  in  1  asynchronous reset, active low
- iIN_VALID  in  1  input sample valid
- iIN_DATA  in  D_BIT  input sample
- oIN_READY  out  1  loader accepts a sample this cycle
- oWR_DATA  out  D_BIT  write data to bank set A, all 4 banks
- oWE  out  4  one-hot per-bank write enable, bank set A
- oADDR_WR  out  A_BIT  write address, shared by all banks
- oFHT_START  out  1  one-cycle start pulse to the FHT controller
- iFHT_RDY  in  1  FHT controller ready (high when idle)
- iSRC_SEL  in  1  bank set holding the result (0 = A, 1 = B); sampled at the iFHT_RDY rising edge
- oADDR_RD  out  A_BIT  read address, shared by all banks
- oRD_SET  out  1  registered iSRC_SEL; drives the read-side bank-set mux
- iRD_DATA  in  4*D_BIT  read data {bank3, bank2, bank1, bank0}
- oOUT_VALID  out  1  output sample valid
- oOUT_DATA  out  D_BIT  output sample
- iOUT_READY  in  1  downstream accepts a sample
- oOUT_LAST  out  1  marks output sample 1023
- oBUSY  out  1  high in every state except IDLE

Behaviour:
- Reset values: all outputs 0 except oIN_READY = 1. State = IDLE; all counters = 0.
- State machine:
  - IDLE -> LOAD on the first accepted sample.
  - LOAD -> START after sample 1023 is accepted.
  - START -> WAIT_BUSY after one cycle; oFHT_START = 1 only in START.
  - WAIT_BUSY -> WAIT_DONE when iFHT_RDY = 0.
  - WAIT_DONE -> UNLOAD when iFHT_RDY = 1; iSRC_SEL is latched into oRD_SET on this transition.
  - UNLOAD -> DRAIN after read address 1023 has been issued.
  - DRAIN -> IDLE when sample 1023 is accepted downstream.
- oIN_READY = 1 in IDLE and LOAD, 0 elsewhere; inputs are ignored outside IDLE/LOAD.
- Load addressing, per accepted sample n (10-bit count):
  - r = bitrev10(n); bank = r[1:0]; address = r[9:2].
  - oWE, oADDR_WR and oWR_DATA are registered and appear one cycle after acceptance.
  - oWE is 0 on cycles with no accepted sample.
- Unload addressing, per sample k: bank = k[1:0], address = k[9:2].
- Unload issue rule:
  - A read is issued when the skid FIFO's free slots, minus reads in flight, is at least 1.
  - Each read's bank index is tagged through an RD_LAT-deep shift register.
  - Returning data is muxed from iRD_DATA by the tag and pushed into the skid FIFO.
  - With iOUT_READY held high, throughput is one sample per cycle; first oOUT_VALID appears RD_LAT+1 cycles after entering UNLOAD.
- Output handshake: a sample transfers when oOUT_VALID & iOUT_READY. oOUT_DATA and oOUT_LAST stay stable while valid and not ready.
- oOUT_LAST = 1 only on the sample with k = 1023.
- Counter wrap: the 10-bit counters wrap to 0 on the 1023 -> 0 transition; no extra state is needed.
- A start-like condition during WAIT_BUSY or WAIT_DONE is impossible: loading is blocked there.
- iFHT_RDY glitches in WAIT_BUSY: the machine waits strictly for the low level before watching for the high level.
- Reset asserted mid-operation: return to IDLE, clear counters and the FIFO, drive oWE = 0, drop oOUT_VALID. A partially written frame is discarded.
- Simultaneous push and pop on a full FIFO are allowed; the count is unchanged.

Decomposition:
- Shared package fht_pkg holds:
  - N_POINT = 1024, N_BANK = 4, LOG2_N = 10
  - state enum: IDLE, LOAD, START, WAIT_BUSY, WAIT_DONE, UNLOAD, DRAIN
  - bitrev10 function
- One sub-module fht_out_skid: a synchronous FIFO of depth RD_LAT+1, width D_BIT+1 (data plus last), with valid/ready on the output side and a count output used for read-issue credit.

Test Plan:
- Load bit-reversal check:
  - n = 1 -> bank 0, addr 128; n = 3 -> bank 0, addr 192; n = 512 -> bank 1, addr 0; n = 1023 -> bank 3, addr 255.
  - Each write appears with oWE one-hot one cycle after acceptance.
- Start handshake:
  - After sample 1023, oFHT_START is exactly one cycle and oIN_READY = 0.
  - A model holds iFHT_RDY low for 100 cycles, then high with iSRC_SEL = 1 -> oRD_SET = 1 and oADDR_RD starts at 0.
- Unload streaming with iOUT_READY = 1 and RAM model data = {bank, addr}:
  - Output k = bank + 4*addr, outputs k = 0..1023 contiguous.
  - oOUT_LAST only at k = 1023; the FSM then returns to IDLE.
- Backpressure:
  - iOUT_READY toggles in a random 30% pattern, including 10-cycle stalls -> no loss or duplication, data stable while stalled.
  - FIFO never overflows, for RD_LAT = 1, 2 and 3.
- Input gaps: iIN_VALID at 50% duty -> addresses still follow bitrev order, and no writes occur on idle cycles.
- Reset mid-load at n = 500, then reload a full frame:
  - Outputs return to reset values, with oIN_READY = 1 immediately after reset release.
  - The reloaded frame's addressing restarts at n = 0.
